debounce: RTL and testbench

- Filters a single already-synchronized input bit, e.g. the output of the two-flop synchronizer on a pushbutton or switch pin.
- Produces a clean level plus one-cycle rise and fall pulses for downstream control logic.
- A level change is accepted only after the input holds the new value for STABLE_TICKS consecutive qualifying cycles.
- An optional tick input lets a shared prescaler stretch the filter window without widening the counter.

---
 rtl/debounce.sv | 78 +++++++
 tb/tb_debounce.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce.sv
// Debounces one pre-synchronized bit into a clean level plus rise/fall pulses.
// Latency STABLE_TICKS counted cycles from first mismatch to level flip; tick=0 freezes progress.
module debounce #(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = $clog2(STABLE_TICKS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] STABLE_HI = 2'd1;
    localparam logic [1:0] ARM_HI    = 2'd2;
    localparam logic [1:0] ARM_LO    = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

    generate
        if (STABLE_TICKS < 1) begin : g_bad_param
            $error("debounce: STABLE_TICKS must be at least 1");
        end
    endgenerate

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             level_nxt, rise_nxt, fall_nxt;
    logic             mismatch;

    always_comb begin
        mismatch  = d ^ level;
        state_nxt = state;
        count_nxt = count;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (!mismatch) begin
            // Any agreeing sample, counted or not, throws away partial progress.
            count_nxt = '0;
            state_nxt = level ? STABLE_HI : STABLE_LO;
        end else if (tick) begin
            if (count == LAST) begin
                level_nxt = ~level;
                rise_nxt  = ~level;
                fall_nxt  = level;
                count_nxt = '0;
                state_nxt = level ? STABLE_LO : STABLE_HI;
            end else begin
                count_nxt = count + CNT_W'(1);
                state_nxt = level ? ARM_LO : ARM_HI;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STABLE_LO;
            count <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= (count_nxt != '0);
        end
    end

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: a 4-tick build and a 1-tick build checked against a run-length model.
module tb_debounce;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic t4 = 1'b1, d4 = 1'b0, t1 = 1'b1, d1 = 1'b0;
    logic level4, rise4, fall4, busy4;
    logic level1, rise1, fall1, busy1;

    int checks   = 0;
    int failures = 0;

    // Model: number of counted samples in the current unbroken run of disagreeing input.
    bit m_level[2];
    bit m_rise[2];
    bit m_fall[2];
    int m_run[2];

    always #5 clk = ~clk;

    debounce #(.STABLE_TICKS(4)) u_dut4 (
        .clk(clk), .rst(rst), .tick(t4), .d(d4),
        .level(level4), .rise(rise4), .fall(fall4), .busy(busy4)
    );

    debounce #(.STABLE_TICKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tick(t1), .d(d1),
        .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    function automatic logic [3:0] exp_out(input int i);
        return {m_level[i], m_rise[i], m_fall[i], (m_run[i] != 0)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_level[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int n, input bit dv, input bit tv);
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (dv != m_level[i]) begin
            if (tv) m_run[i]++;
            if (m_run[i] == n) begin
                m_level[i] = ~m_level[i];
                m_rise[i]  = m_level[i];
                m_fall[i]  = ~m_level[i];
                m_run[i]   = 0;
            end
        end else begin
            m_run[i] = 0;
        end
    endtask

    // Applies inputs, advances one edge, updates the model, then settles 1 time unit.
    task automatic drive_cycle(input bit a, input bit ta, input bit b, input bit tb_);
        d4 = a; t4 = ta; d1 = b; t1 = tb_;
        @(posedge clk);
        model_step(0, 4, a, ta);
        model_step(1, 1, b, tb_);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; d4 = 1'b0; t4 = 1'b1; d1 = 1'b0; t1 = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({level4, rise4, fall4, busy4} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_dut4 got=%b want=0000", {level4, rise4, fall4, busy4});
        end
        checks++;
        if ({level1, rise1, fall1, busy1} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_dut1 got=%b want=0000", {level1, rise1, fall1, busy1});
        end
        rst = 1'b1;
    endtask

    task automatic test_clean_step();
        logic [3:0] want;
        for (int e = 1; e <= 6; e++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
            want = (e <= 3) ? 4'b0001 : (e == 4) ? 4'b1100 : 4'b1000;
            checks++;
            if ({level4, rise4, fall4, busy4} !== want) begin
                failures++;
                $display("FAIL clean_step edge=%0d got=%b want=%b", e, {level4, rise4, fall4, busy4}, want);
            end
        end
    endtask

    task automatic test_glitch();
        int pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        int rises = 0;
        for (int j = 0; j < 5; j++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (level4 !== 1'b0) begin
            failures++;
            $display("FAIL glitch_settle got=%b want=0", level4);
        end
        for (int j = 0; j < 8; j++) begin
            drive_cycle(pat[j][0], 1'b1, 1'b0, 1'b1);
            rises += int'(rise4);
            checks++;
            if ({level4, rise4, fall4, busy4} !== exp_out(0)) begin
                failures++;
                $display("FAIL glitch j=%0d got=%b want=%b", j, {level4, rise4, fall4, busy4}, exp_out(0));
            end
        end
        checks++;
        if (rises != 1 || level4 !== 1'b1) begin
            failures++;
            $display("FAIL glitch_rises got=%0d level=%b want=1 level=1", rises, level4);
        end
    endtask

    task automatic test_fall_bounce();
        int pat[6] = '{0, 1, 0, 0, 0, 0};
        int falls = 0, rises = 0, fall_at = -1;
        for (int j = 0; j < 6; j++) begin
            drive_cycle(pat[j][0], 1'b1, 1'b0, 1'b1);
            falls += int'(fall4);
            rises += int'(rise4);
            if (fall4) fall_at = j;
            checks++;
            if ({level4, rise4, fall4, busy4} !== exp_out(0)) begin
                failures++;
                $display("FAIL fall_bounce j=%0d got=%b want=%b", j, {level4, rise4, fall4, busy4}, exp_out(0));
            end
        end
        checks++;
        if (falls != 1 || rises != 0 || fall_at != 5 || level4 !== 1'b0) begin
            failures++;
            $display("FAIL fall_bounce_sum falls=%0d rises=%0d at=%0d level=%b want 1 0 5 0",
                     falls, rises, fall_at, level4);
        end
    endtask

    task automatic test_tick_gating();
        for (int j = 0; j < 5; j++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 12; j++) begin
            drive_cycle(1'b1, (j % 3) == 2, 1'b0, 1'b1);
            checks++;
            if (level4 !== ((j == 11) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL tick_rise j=%0d got=%b want=%b", j, level4, (j == 11));
            end
        end
        for (int j = 0; j < 5; j++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        // Two ticks of progress, then a glitch on a tick=0 cycle must restart the count.
        for (int j = 0; j < 19; j++) begin
            drive_cycle((j == 6) ? 1'b0 : 1'b1, (j % 3) == 2, 1'b0, 1'b1);
            checks++;
            if ({level4, rise4, fall4, busy4} !== exp_out(0)) begin
                failures++;
                $display("FAIL tick_glitch j=%0d got=%b want=%b", j, {level4, rise4, fall4, busy4}, exp_out(0));
            end
            if (j == 11 || j == 16 || j == 17) begin
                checks++;
                if (level4 !== (j == 17)) begin
                    failures++;
                    $display("FAIL tick_glitch_level j=%0d got=%b want=%b", j, level4, (j == 17));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] want;
        for (int j = 0; j < 5; j++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (busy4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_busy got=%b want=1", busy4);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({level4, rise4, fall4, busy4} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_async got=%b want=0000", {level4, rise4, fall4, busy4});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
            want = (e <= 3) ? 4'b0001 : (e == 4) ? 4'b1100 : 4'b1000;
            checks++;
            if ({level4, rise4, fall4, busy4} !== want) begin
                failures++;
                $display("FAIL reset_mid_requal edge=%0d got=%b want=%b", e, {level4, rise4, fall4, busy4}, want);
            end
        end
    endtask

    task automatic test_st1_toggle();
        bit prev_d = d1;
        bit dv;
        for (int j = 0; j < 12; j++) begin
            dv = ~prev_d;
            drive_cycle(d4, 1'b1, dv, 1'b1);
            checks++;
            if (level1 !== dv || rise1 !== dv || fall1 !== ~dv || busy1 !== 1'b0) begin
                failures++;
                $display("FAIL st1_toggle j=%0d got=%b want=%b", j, {level1, rise1, fall1, busy1}, {dv, dv, ~dv, 1'b0});
            end
            prev_d = dv;
        end
    endtask

    task automatic test_random();
        bit a = d4, b = d1;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 5) == 0) a = ~a;
            if ($urandom_range(0, 1) == 0) b = ~b;
            drive_cycle(a, $urandom_range(0, 3) != 0, b, $urandom_range(0, 2) != 0);
            checks++;
            if ({level4, rise4, fall4, busy4} !== exp_out(0)) begin
                failures++;
                $display("FAIL random4 j=%0d got=%b want=%b", j, {level4, rise4, fall4, busy4}, exp_out(0));
            end
            checks++;
            if ({level1, rise1, fall1, busy1} !== exp_out(1) || (rise1 && fall1)) begin
                failures++;
                $display("FAIL random1 j=%0d got=%b want=%b", j, {level1, rise1, fall1, busy1}, exp_out(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_fall_bounce();
        test_tick_gating();
        test_reset_mid();
        test_st1_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
